// File: rtl/mem_copy_master.sv
// Copies LEN 32-bit words from SRC_ADDR to DST_ADDR over a single memory port, one read/write pair per word.
// Latency is 2*LEN busy cycles followed by a one-cycle DONE. START is ignored (never queued) outside IDLE.
module mem_copy_master #(
  parameter int          LEN_W     = 16,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             START,
  input  logic [31:0]      SRC_ADDR,
  input  logic [31:0]      DST_ADDR,
  input  logic [LEN_W-1:0] LEN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [31:0]      CHKSUM,
  output logic [31:0]      M_ADDR,
  output logic             M_RW,
  output logic [31:0]      M_WD,
  input  logic [31:0]      M_RD
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  state_t           state, state_nxt;
  logic [31:0]      src_ptr, dst_ptr, src_ptr_d, dst_ptr_d;
  logic [31:0]      m_addr_d, m_wd_d, chksum_d;
  logic [LEN_W-1:0] cnt, cnt_d;
  logic             m_rw_d, busy_d, done_d, err_d;
  logic             misaligned, last_word;

  assign misaligned = (SRC_ADDR[1:0] != 2'b00) || (DST_ADDR[1:0] != 2'b00);
  assign last_word  = (cnt == LEN_W'(1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (START) begin
          if (misaligned || (LEN == '0)) state_nxt = S_FIN;
          else                           state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = S_WR;
      S_WR:    state_nxt = last_word ? S_FIN : S_RD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for every registered output; flag outputs follow the state being entered.
  always_comb begin
    src_ptr_d = src_ptr;
    dst_ptr_d = dst_ptr;
    cnt_d     = cnt;
    m_addr_d  = M_ADDR;
    m_rw_d    = M_RW;
    m_wd_d    = M_WD;
    chksum_d  = CHKSUM;
    busy_d    = (state_nxt == S_RD) || (state_nxt == S_WR);
    done_d    = (state_nxt == S_FIN);
    err_d     = (state == S_IDLE) && START && misaligned;
    case (state)
      S_IDLE: begin
        if (START && !misaligned) begin
          chksum_d = '0;
          if (LEN != '0) begin
            src_ptr_d = SRC_ADDR;
            dst_ptr_d = DST_ADDR;
            cnt_d     = LEN;
            m_addr_d  = SRC_ADDR;
            m_rw_d    = 1'b0;
          end
        end
      end
      S_RD: begin
        m_wd_d   = M_RD;
        chksum_d = CHKSUM + M_RD;
        m_addr_d = dst_ptr;
        m_rw_d   = 1'b1;
      end
      S_WR: begin
        m_rw_d    = 1'b0;
        cnt_d     = cnt - LEN_W'(1);
        src_ptr_d = src_ptr + ADDR_STEP;
        dst_ptr_d = dst_ptr + ADDR_STEP;
        m_addr_d  = last_word ? 32'd0 : (src_ptr + ADDR_STEP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      M_ADDR  <= '0;
      M_RW    <= 1'b0;
      M_WD    <= '0;
      CHKSUM  <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      src_ptr <= src_ptr_d;
      dst_ptr <= dst_ptr_d;
      cnt     <= cnt_d;
      M_ADDR  <= m_addr_d;
      M_RW    <= m_rw_d;
      M_WD    <= m_wd_d;
      CHKSUM  <= chksum_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
      ERR     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master: 256-word memory model, write scoreboard checked on the falling edge.
module tb_mem_copy_master;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        CLK, RSTn, START;
  logic [31:0] SRC_ADDR, DST_ADDR;
  logic [15:0] LEN;
  logic        BUSY, DONE, ERR, M_RW;
  logic [31:0] CHKSUM, M_ADDR, M_WD, M_RD;

  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_dat;
  wr_t         exp_q[$];
  int          n_chk, n_fail;

  mem_copy_master #(.LEN_W(16), .ADDR_STEP(32'd4)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CHKSUM(CHKSUM), .M_ADDR(M_ADDR), .M_RW(M_RW),
    .M_WD(M_WD), .M_RD(M_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign M_RD = mem[M_ADDR[9:2]];

  always @(posedge CLK) begin
    if (M_RW)       mem[M_ADDR[9:2]] <= M_WD;
    else if (pl_en) mem[pl_idx] <= pl_dat;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write the DUT issues must match the head of the expected-write queue.
  always @(negedge CLK) begin
    if (RSTn === 1'b1 && M_RW === 1'b1) begin
      n_chk++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL wr_unexpected observed addr=%h data=%h expected no write", M_ADDR, M_WD);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", M_ADDR, e.a);
        chk("wr_data", M_WD, e.d);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic poke(input int idx, input logic [31:0] dat);
    pl_idx = 8'(idx);
    pl_dat = dat;
    pl_en  = 1'b1;
    step();
    pl_en  = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Drives a request across one edge; returns #1 into cycle 1.
  task automatic start_req(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                           input bit hold);
    SRC_ADDR = src;
    DST_ADDR = dst;
    LEN      = len;
    START    = 1'b1;
    step();
    if (!hold) START = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n;
    n = 0;
    while (DONE !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk(tag, {31'd0, DONE}, 32'd1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    RSTn = 1'b0; START = 1'b0; SRC_ADDR = '0; DST_ADDR = '0; LEN = '0;
    pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    step(); step();
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_chksum", CHKSUM, 32'd0);
    chk("rst_maddr", M_ADDR, 32'd0);
    chk("rst_mrw", {31'd0, M_RW}, 32'd0);
    chk("rst_mwd", M_WD, 32'd0);
    RSTn = 1'b1;
    step();

    // Basic 4-word copy 0 -> 64.
    for (int i = 0; i < 4; i++) begin
      poke(i, 32'(i + 1));
      poke(16 + i, 32'd0);
    end
    for (int i = 0; i < 4; i++) push_wr(32'd64 + 32'(4 * i), 32'(i + 1));
    start_req(32'd0, 32'd64, 16'd4, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("cp_busy_c%0d", c), {31'd0, BUSY}, 32'd1);
      chk($sformatf("cp_mrw_c%0d", c), {31'd0, M_RW}, (c % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cp_done_c%0d", c), {31'd0, DONE}, 32'd0);
      if (c % 2 == 1) chk($sformatf("cp_rdaddr_c%0d", c), M_ADDR, 32'(2 * (c - 1)));
      step();
    end
    chk("cp_done_c9", {31'd0, DONE}, 32'd1);
    chk("cp_busy_c9", {31'd0, BUSY}, 32'd0);
    chk("cp_err_c9", {31'd0, ERR}, 32'd0);
    chk("cp_chksum", CHKSUM, 32'd10);
    step();
    chk("cp_done_c10", {31'd0, DONE}, 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("cp_mem%0d", i), mem[16 + i], 32'(i + 1));

    // Misaligned source, then misaligned destination: rejected, checksum kept.
    start_req(32'd2, 32'd64, 16'd3, 1'b0);
    chk("mis_src_done", {31'd0, DONE}, 32'd1);
    chk("mis_src_err", {31'd0, ERR}, 32'd1);
    chk("mis_src_busy", {31'd0, BUSY}, 32'd0);
    chk("mis_src_chksum", CHKSUM, 32'd10);
    step();
    chk("mis_err_clear", {31'd0, ERR}, 32'd0);
    start_req(32'd0, 32'd65, 16'd3, 1'b0);
    chk("mis_dst_err", {31'd0, ERR}, 32'd1);
    step();
    chk("mis_mem_untouched", mem[16], 32'd1);

    // Zero-length request.
    start_req(32'd0, 32'd64, 16'd0, 1'b0);
    chk("len0_done", {31'd0, DONE}, 32'd1);
    chk("len0_err", {31'd0, ERR}, 32'd0);
    chk("len0_chksum", CHKSUM, 32'd0);
    chk("len0_mrw", {31'd0, M_RW}, 32'd0);
    step();

    // Reset during the 4th word's write cycle of an 8-word copy.
    for (int i = 0; i < 8; i++) begin
      poke(32 + i, 32'h100 + 32'(i));
      poke(48 + i, 32'd0);
    end
    for (int i = 0; i < 3; i++) push_wr(32'd192 + 32'(4 * i), 32'h100 + 32'(i));
    start_req(32'd128, 32'd192, 16'd8, 1'b0);
    for (int c = 1; c < 8; c++) step();
    chk("rst_mid_mrw_before", {31'd0, M_RW}, 32'd1);
    RSTn = 1'b0;
    #1;
    chk("rst_mid_mrw", {31'd0, M_RW}, 32'd0);
    chk("rst_mid_busy", {31'd0, BUSY}, 32'd0);
    step(); step();
    RSTn = 1'b1;
    step();
    chk("rst_mid_q_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("rst_mid_mem%0d", i), mem[48 + i], 32'h100 + 32'(i));
    chk("rst_mid_mem3", mem[51], 32'd0);

    // Address wrap with checksum overflow: 0xFFFFFFFF + 2 + 5 = 6.
    poke(254, 32'hFFFF_FFFF);
    poke(255, 32'd2);
    poke(0, 32'd5);
    push_wr(32'd256, 32'hFFFF_FFFF);
    push_wr(32'd260, 32'd2);
    push_wr(32'd264, 32'd5);
    start_req(32'hFFFF_FFF8, 32'd256, 16'd3, 1'b0);
    chk("wrap_rd0", M_ADDR, 32'hFFFF_FFF8);
    step(); step();
    chk("wrap_rd1", M_ADDR, 32'hFFFF_FFFC);
    step(); step();
    chk("wrap_rd2", M_ADDR, 32'h0000_0000);
    step(); step();
    chk("wrap_done", {31'd0, DONE}, 32'd1);
    chk("wrap_chksum", CHKSUM, 32'd6);
    step();
    chk("wrap_mem2", mem[66], 32'd5);

    // START held high through a 2-word copy: 0xFFFFFFFF + 2 = 1, restarts after the IDLE cycle.
    for (int k = 0; k < 2; k++) begin
      push_wr(32'd320, 32'hFFFF_FFFF);
      push_wr(32'd324, 32'd2);
    end
    start_req(32'hFFFF_FFF8, 32'd320, 16'd2, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("hold_busy_c%0d", c), {31'd0, BUSY}, 32'd1);
      step();
    end
    chk("hold_done_c5", {31'd0, DONE}, 32'd1);
    chk("hold_chksum", CHKSUM, 32'd1);
    step();
    chk("hold_idle_busy", {31'd0, BUSY}, 32'd0);
    chk("hold_idle_done", {31'd0, DONE}, 32'd0);
    step();
    chk("hold_restart_busy", {31'd0, BUSY}, 32'd1);
    START = 1'b0;
    wait_done(10, "hold_second_done");
    chk("hold_second_chksum", CHKSUM, 32'd1);
    step(); step();
    chk("hold_busy_after", {31'd0, BUSY}, 32'd0);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
